dir_validator: RTL and testbench

//  Checks one direction of a candidate Othello move. From a start cell it

---
 rtl/othello_pkg.sv | 38 +++
 rtl/board_step_addr.sv | 26 ++
 rtl/dir_validator.sv | 204 ++++++++++++++++++++
 tb/tb_dir_validator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared Othello board definitions: cell codes, board geometry, direction steps,
// and the direction-validator state encoding.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_BLACK  = 2'b01;
  localparam logic [1:0] CELL_WHITE  = 2'b10;
  localparam logic [1:0] CELL_BORDER = 2'b11;

  localparam int BOARD_W     = 10;
  localparam int BOARD_CELLS = 100;
  localparam int POS_W       = 7;
  localparam int STEP_W      = 5;
  localparam int MAX_RUN     = 8;
  localparam int RUN_W       = 4;

  // Two's-complement 5-bit direction steps on the 10-wide bordered board
  localparam logic [STEP_W-1:0] STEP_UP    = 5'b10110;
  localparam logic [STEP_W-1:0] STEP_DOWN  = 5'b01010;
  localparam logic [STEP_W-1:0] STEP_LEFT  = 5'b11111;
  localparam logic [STEP_W-1:0] STEP_RIGHT = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } dir_state_e;

  function automatic logic [1:0] own_code(input logic player);
    return player ? CELL_WHITE : CELL_BLACK;
  endfunction

  function automatic logic [1:0] opp_code(input logic player);
    return player ? CELL_BLACK : CELL_WHITE;
  endfunction

endpackage

// File: rtl/board_step_addr.sv
// Combinational board walker: next = cur + sign-extended step (mod 2^POS_W),
// flagging any index past the last board cell as border.
module board_step_addr
  import othello_pkg::*;
#(
  parameter int P_POS_W  = POS_W,
  parameter int P_STEP_W = STEP_W
) (
  input  logic [P_POS_W-1:0]  cur_i,
  input  logic [P_STEP_W-1:0] step_i,
  output logic [P_POS_W-1:0]  nxt_o,
  output logic                border_o
);

  localparam logic [P_POS_W-1:0] LIMIT = P_POS_W'(BOARD_CELLS);

  logic [P_POS_W-1:0] step_ext_s;

  // Sign-extend the step and wrap the sum to the index width
  always_comb begin
    step_ext_s = {{(P_POS_W-P_STEP_W){step_i[P_STEP_W-1]}}, step_i};
    nxt_o      = cur_i + step_ext_s;
    border_o   = (nxt_o >= LIMIT);
  end

endmodule

// File: rtl/dir_validator.sv
// Walks one direction from a candidate move and reports whether a run of opponent
// discs is closed by an own disc. DIR_VALI_RUNLEN_EN adds the run_len_o output.
module dir_validator
  import othello_pkg::*;
#(
  parameter int MAX_RUN = othello_pkg::MAX_RUN,
  parameter int POS_W   = othello_pkg::POS_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              ld,
  input  logic [STEP_W-1:0] step_in,
  input  logic [POS_W-1:0]  pos_in,
  input  logic              player_in,
  output logic [POS_W-1:0]  board_addr_o,
  input  logic [1:0]        board_data_i,
  output logic              s_done_o,
  output logic              dir_status_o
`ifdef DIR_VALI_RUNLEN_EN
  ,
  output logic [RUN_W-1:0]  run_len_o
`endif
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

  dir_state_e        state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              player_q, player_d;
  logic [POS_W-1:0]  cur_q, cur_d;
  logic              border_q, border_d;
  logic [RUN_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  addr_q, addr_d;
  logic              done_q, done_d;
  logic              status_q, status_d;
`ifdef DIR_VALI_RUNLEN_EN
  logic [RUN_W-1:0]  run_len_q, run_len_d;
`endif

  logic [POS_W-1:0]  pos_eff_s;
  logic [STEP_W-1:0] step_eff_s;
  logic              player_eff_s;
  logic [POS_W-1:0]  base_s;
  logic [STEP_W-1:0] step_sel_s;
  logic [POS_W-1:0]  nxt_s;
  logic              nxt_border_s;
  logic [1:0]        cell_s;

  // A load in the same cycle as enable takes effect for that walk
  always_comb begin
    if (ld) begin
      pos_eff_s    = pos_in;
      step_eff_s   = step_in;
      player_eff_s = player_in;
    end else begin
      pos_eff_s    = pos_q;
      step_eff_s   = step_q;
      player_eff_s = player_q;
    end
    if (state_q == ST_IDLE) begin
      base_s     = pos_eff_s;
      step_sel_s = step_eff_s;
    end else begin
      base_s     = cur_q;
      step_sel_s = step_q;
    end
    if (border_q) begin
      cell_s = CELL_BORDER;
    end else begin
      cell_s = board_data_i;
    end
  end

  board_step_addr #(
    .P_POS_W  (POS_W),
    .P_STEP_W (STEP_W)
  ) u_step (
    .cur_i    (base_s),
    .step_i   (step_sel_s),
    .nxt_o    (nxt_s),
    .border_o (nxt_border_s)
  );

  // Next-state and registered-output logic of the walk FSM
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    step_d   = step_q;
    player_d = player_q;
    cur_d    = cur_q;
    border_d = border_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    status_d = status_q;
`ifdef DIR_VALI_RUNLEN_EN
    run_len_d = run_len_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ld) begin
          pos_d    = pos_in;
          step_d   = step_in;
          player_d = player_in;
        end else begin
          pos_d    = pos_q;
        end
        if (enable) begin
          status_d = 1'b0;
          cnt_d    = {RUN_W{1'b0}};
`ifdef DIR_VALI_RUNLEN_EN
          run_len_d = {RUN_W{1'b0}};
`endif
          if (step_eff_s == {STEP_W{1'b0}}) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_FETCH;
            cur_d    = nxt_s;
            border_d = nxt_border_s;
            addr_d   = nxt_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if ((cell_s == opp_code(player_q)) && (cnt_q < RUN_MAX)) begin
          state_d  = ST_FETCH;
          cnt_d    = cnt_q + 4'd1;
          cur_d    = nxt_s;
          border_d = nxt_border_s;
          addr_d   = nxt_s;
        end else if ((cell_s == own_code(player_q)) && (cnt_q != {RUN_W{1'b0}})) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          status_d = 1'b1;
`ifdef DIR_VALI_RUNLEN_EN
          run_len_d = cnt_q;
`endif
        end else begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          status_d = 1'b0;
`ifdef DIR_VALI_RUNLEN_EN
          run_len_d = {RUN_W{1'b0}};
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any walk without a done pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pos_q    <= {POS_W{1'b0}};
      step_q   <= {STEP_W{1'b0}};
      player_q <= 1'b0;
      cur_q    <= {POS_W{1'b0}};
      border_q <= 1'b0;
      cnt_q    <= {RUN_W{1'b0}};
      addr_q   <= {POS_W{1'b0}};
      done_q   <= 1'b0;
      status_q <= 1'b0;
`ifdef DIR_VALI_RUNLEN_EN
      run_len_q <= {RUN_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      player_q <= player_d;
      cur_q    <= cur_d;
      border_q <= border_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      status_q <= status_d;
`ifdef DIR_VALI_RUNLEN_EN
      run_len_q <= run_len_d;
`endif
    end
  end

  assign board_addr_o = addr_q;
  assign s_done_o     = done_q;
  assign dir_status_o = status_q;
`ifdef DIR_VALI_RUNLEN_EN
  assign run_len_o    = run_len_q;
`endif

endmodule

// File: tb/tb_dir_validator.sv
// Scoreboard bench for dir_validator against a registered-read board RAM model.
module tb_dir_validator;
  import othello_pkg::*;

  logic       clock = 1'b0;
  logic       reset, enable, ld, player_in;
  logic [4:0] step_in;
  logic [6:0] pos_in;
  logic [6:0] board_addr_o;
  logic [1:0] board_data_i;
  logic       s_done_o, dir_status_o;
`ifdef DIR_VALI_RUNLEN_EN
  logic [3:0] run_len_o;
`endif

  always #5 clock = ~clock;

  dir_validator dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .ld           (ld),
    .step_in      (step_in),
    .pos_in       (pos_in),
    .player_in    (player_in),
    .board_addr_o (board_addr_o),
    .board_data_i (board_data_i),
    .s_done_o     (s_done_o),
    .dir_status_o (dir_status_o)
`ifdef DIR_VALI_RUNLEN_EN
    ,
    .run_len_o    (run_len_o)
`endif
  );

  logic [1:0] mem [128];
  always @(posedge clock) board_data_i <= mem[board_addr_o];

  int vectors = 0;
  int errs = 0;

  typedef struct {
    int         cyc;
    logic       st;
    logic [3:0] rl;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int         board;
    logic [6:0] pos;
    logic [4:0] step;
    logic       player;
    int         cyc;
    logic       st;
    logic [3:0] rl;
  } vec_t;

  // 0: opening position; 1: col 1 rows 1..7 white, black at 81; 2: col 1 rows 1..9 white.
  // Cells >= 100 hold black discs so only the out-of-range flag can stop a walk there.
  task automatic load_board(input int sel);
    for (int i = 0; i < 128; i++) begin
      if (i >= 100) mem[i] = CELL_BLACK;
      else if ((i / 10 == 0) || (i / 10 == 9) || (i % 10 == 0) || (i % 10 == 9)) mem[i] = CELL_BORDER;
      else mem[i] = CELL_EMPTY;
    end
    mem[44] = CELL_WHITE; mem[55] = CELL_WHITE;
    mem[45] = CELL_BLACK; mem[54] = CELL_BLACK;
    if (sel == 1) begin
      for (int r = 1; r <= 7; r++) mem[r*10+1] = CELL_WHITE;
      mem[81] = CELL_BLACK;
    end else if (sel == 2) begin
      for (int r = 1; r <= 9; r++) mem[r*10+1] = CELL_WHITE;
    end
  endtask

  task automatic start_walk(input logic [6:0] pos, input logic [4:0] step, input logic player,
                            input logic use_ld);
    @(negedge clock);
    pos_in = pos; step_in = step; player_in = player;
    ld = use_ld; enable = 1'b1;
  endtask

  // Observes cycles 1..60 after the start cycle; optional stray ld+enable at poke_at
  task automatic wait_done(input int poke_at, output int cyc, output logic st,
                           output logic [3:0] rl, output logic got);
    got = 1'b0; cyc = 0; st = 1'b0; rl = 4'd0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clock);
      if (c == 1) begin enable = 1'b0; ld = 1'b0; end
      if (c == poke_at) begin
        enable = 1'b1; ld = 1'b1; pos_in = 7'd43; step_in = STEP_UP; player_in = 1'b1;
      end
      if (c == poke_at + 1) begin enable = 1'b0; ld = 1'b0; end
      if (s_done_o === 1'b1) begin
        got = 1'b1; cyc = c; st = dir_status_o;
`ifdef DIR_VALI_RUNLEN_EN
        rl = run_len_o;
`endif
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; ld = 1'b0;
    pos_in = 7'd0; step_in = 5'd0; player_in = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (board_addr_o !== 7'd0) begin errs++; $display("FAIL reset_addr got %0d want 0", board_addr_o); end
    vectors++;
    if (s_done_o !== 1'b0 || dir_status_o !== 1'b0) begin
      errs++; $display("FAIL reset_outs got done=%b st=%b want 0 0", s_done_o, dir_status_o);
    end
`ifdef DIR_VALI_RUNLEN_EN
    vectors++;
    if (run_len_o !== 4'd0) begin errs++; $display("FAIL reset_runlen got %0d want 0", run_len_o); end
`endif
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_walks();
    vec_t tbl[10];
    exp_t e;
    int cyc; logic st; logic [3:0] rl; logic got;
    tbl[0] = '{0, 7'd43, STEP_RIGHT, 1'b0, 5,  1'b1, 4'd1};
    tbl[1] = '{0, 7'd43, STEP_UP,    1'b0, 3,  1'b0, 4'd0};
    tbl[2] = '{0, 7'd9,  STEP_RIGHT, 1'b1, 3,  1'b0, 4'd0};
    tbl[3] = '{0, 7'd95, STEP_DOWN,  1'b1, 3,  1'b0, 4'd0};
    tbl[4] = '{1, 7'd1,  STEP_DOWN,  1'b0, 17, 1'b1, 4'd7};
    tbl[5] = '{2, 7'd1,  STEP_DOWN,  1'b0, 19, 1'b0, 4'd0};
    tbl[6] = '{0, 7'd53, STEP_RIGHT, 1'b1, 5,  1'b1, 4'd1};
    tbl[7] = '{0, 7'd56, STEP_LEFT,  1'b1, 3,  1'b0, 4'd0};
    tbl[8] = '{0, 7'd43, 5'd0,       1'b0, 1,  1'b0, 4'd0};
    tbl[9] = '{0, 7'd65, STEP_UP,    1'b0, 5,  1'b1, 4'd1};
    foreach (tbl[i]) begin
      load_board(tbl[i].board);
      start_walk(tbl[i].pos, tbl[i].step, tbl[i].player, 1'b1);
      sb_q.push_back('{tbl[i].cyc, tbl[i].st, tbl[i].rl});
      wait_done(0, cyc, st, rl, got);
      e = sb_q.pop_front();
      vectors++;
      if (!got) begin
        errs++; $display("FAIL walk%0d_timeout no done within 60 cycles want cycle %0d", i, e.cyc);
      end else begin
        if (cyc != e.cyc) begin errs++; $display("FAIL walk%0d_cycle got %0d want %0d", i, cyc, e.cyc); end
        vectors++;
        if (st !== e.st) begin errs++; $display("FAIL walk%0d_status got %b want %b", i, st, e.st); end
`ifdef DIR_VALI_RUNLEN_EN
        vectors++;
        if (rl !== e.rl) begin errs++; $display("FAIL walk%0d_runlen got %0d want %0d", i, rl, e.rl); end
`endif
        repeat (2) @(negedge clock);
        vectors++;
        if (dir_status_o !== e.st) begin
          errs++; $display("FAIL walk%0d_hold got %b want %b", i, dir_status_o, e.st);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc, extra; logic st; logic [3:0] rl; logic got;
    load_board(0);
    start_walk(7'd43, STEP_RIGHT, 1'b0, 1'b1);
    sb_q.push_back('{5, 1'b1, 4'd1});
    wait_done(2, cyc, st, rl, got);
    e = sb_q.pop_front();
    vectors++;
    if (!got || cyc != e.cyc || st !== e.st) begin
      errs++; $display("FAIL busy_enable got done=%b cyc=%0d st=%b want cyc=%0d st=%b", got, cyc, st, e.cyc, e.st);
    end
    extra = 0;
    repeat (10) begin @(negedge clock); if (s_done_o === 1'b1) extra++; end
    vectors++;
    if (extra != 0) begin errs++; $display("FAIL busy_extra_done got %0d pulses want 0", extra); end
    // The stray ld while busy must not have replaced the latched start
    start_walk(7'd99, STEP_UP, 1'b1, 1'b0);
    sb_q.push_back('{5, 1'b1, 4'd1});
    wait_done(0, cyc, st, rl, got);
    e = sb_q.pop_front();
    vectors++;
    if (!got || cyc != e.cyc || st !== e.st) begin
      errs++; $display("FAIL busy_ld got done=%b cyc=%0d st=%b want cyc=%0d st=%b", got, cyc, st, e.cyc, e.st);
    end
  endtask

  task automatic test_reset_mid_walk();
    exp_t e;
    int cyc, pulses; logic st; logic [3:0] rl; logic got;
    load_board(0);
    start_walk(7'd43, STEP_RIGHT, 1'b0, 1'b1);
    @(negedge clock);
    enable = 1'b0; ld = 1'b0;
    vectors++;
    if (board_addr_o !== 7'd44) begin errs++; $display("FAIL fetch_addr got %0d want 44", board_addr_o); end
    reset = 1'b0;
    #1;
    vectors++;
    if (board_addr_o !== 7'd0 || s_done_o !== 1'b0 || dir_status_o !== 1'b0) begin
      errs++; $display("FAIL midreset_outs got addr=%0d done=%b st=%b want 0 0 0", board_addr_o, s_done_o, dir_status_o);
    end
    pulses = 0;
    repeat (2) begin @(negedge clock); if (s_done_o === 1'b1) pulses++; end
    reset = 1'b1;
    repeat (12) begin @(negedge clock); if (s_done_o === 1'b1) pulses++; end
    vectors++;
    if (pulses != 0) begin errs++; $display("FAIL midreset_done got %0d pulses want 0", pulses); end
    // Cleared latch means step 0: immediate done with status 0
    start_walk(7'd43, STEP_RIGHT, 1'b0, 1'b0);
    sb_q.push_back('{1, 1'b0, 4'd0});
    wait_done(0, cyc, st, rl, got);
    e = sb_q.pop_front();
    vectors++;
    if (!got || cyc != e.cyc || st !== e.st) begin
      errs++; $display("FAIL midreset_latch got done=%b cyc=%0d st=%b want cyc=%0d st=%b", got, cyc, st, e.cyc, e.st);
    end
  endtask

  initial begin
    test_reset();
    test_walks();
    test_back_to_back();
    test_reset_mid_walk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
